// File: rtl/hub75_pkg.sv
// Shared constants and helpers for the HUB75 panel-side receiver and display_driver.
package hub75_pkg;
  localparam int RGB_BITS = 3;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  // Address width that never collapses to zero bits (single-row builds).
  function automatic int addr_bits(input int v);
    return (clog2(v) > 0) ? clog2(v) : 1;
  endfunction

  // Bit offset of column col of lane lane inside a packed row image.
  function automatic int pix_ofs(input int lane, input int col, input int columns);
    return (lane * columns + col) * RGB_BITS;
  endfunction
endpackage

// File: rtl/hub75_edge_sync.sv
// Two-stage input register (s1, s2) with a rising-edge strobe taken between the stages.
module hub75_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);
  logic s1_q, s1_d, s2_q, s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign rise = s1_q & ~s2_q;
endmodule

// File: rtl/hub75_panel_receiver.sv
// Panel-end model of the HUB75 link: rebuilds latched rows and measures per-row OE on-time.
// Optional frame statistics (frame_valid/frame_cycles) under HUB75_RX_FRAME_STATS_EN.
module hub75_panel_receiver
  import hub75_pkg::*;
#(
  parameter int SEGMENTS     = 1,
  parameter int ROWS         = 8,
  parameter int COLUMNS      = 32,
  parameter int ONTIME_WIDTH = 24,
  localparam int ROW_W       = addr_bits(ROWS),
  localparam int DATA_W      = SEGMENTS * COLUMNS * RGB_BITS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [RGB_BITS*SEGMENTS-1:0] in_rgb,
  input  logic                      in_oclk,
  input  logic                      in_lat,
  input  logic                      in_oe,
  input  logic [ROW_W-1:0]          in_row,
  output logic                      row_valid,
  output logic [ROW_W-1:0]          row_addr,
  output logic [DATA_W-1:0]         row_data,
  output logic                      err_count,
  output logic                      ontime_valid,
  output logic [ROW_W-1:0]          ontime_row,
  output logic [ONTIME_WIDTH-1:0]   ontime_cycles
`ifdef HUB75_RX_FRAME_STATS_EN
  , output logic                    frame_valid
  , output logic [31:0]             frame_cycles
`endif
);
  localparam int COL_W = clog2(COLUMNS + 1);

  logic oclk_rise, lat_rise;

  hub75_edge_sync u_oclk_sync (.clk(clk), .rst(rst), .d(in_oclk), .rise(oclk_rise));
  hub75_edge_sync u_lat_sync  (.clk(clk), .rst(rst), .d(in_lat),  .rise(lat_rise));

  logic [RGB_BITS*SEGMENTS-1:0] rgb_s1_q, rgb_s1_d;
  logic                         oe_s1_q, oe_s1_d;
  logic [ROW_W-1:0]             row_s1_q, row_s1_d, row_s2_q, row_s2_d;
  logic [COL_W-1:0]             col_cnt_q, col_cnt_d;
  logic                         overrun_q, overrun_d;
  logic [DATA_W-1:0]            buf_q, buf_d;
  logic                         row_valid_q, row_valid_d, err_q, err_d;
  logic [ROW_W-1:0]             row_addr_q, row_addr_d;
  logic [DATA_W-1:0]            row_data_q, row_data_d;
  logic [ONTIME_WIDTH-1:0]      ot_cnt_q, ot_cnt_d, ot_cycles_q, ot_cycles_d, ot_sum;
  logic                         ot_valid_q, ot_valid_d;
  logic [ROW_W-1:0]             ot_row_q, ot_row_d;

  always_comb begin
    rgb_s1_d    = in_rgb;
    oe_s1_d     = in_oe;
    row_s1_d    = in_row;
    row_s2_d    = row_s1_q;
    col_cnt_d   = col_cnt_q;
    overrun_d   = overrun_q;
    buf_d       = buf_q;
    row_valid_d = 1'b0;
    err_d       = 1'b0;
    row_addr_d  = row_addr_q;
    row_data_d  = row_data_q;

    if (oclk_rise) begin
      if (col_cnt_q < COL_W'(COLUMNS)) begin
        for (int s = 0; s < SEGMENTS; s++)
          buf_d[pix_ofs(s, int'(col_cnt_q), COLUMNS) +: RGB_BITS] = rgb_s1_q[s*RGB_BITS +: RGB_BITS];
        col_cnt_d = col_cnt_q + COL_W'(1);
      end else begin
        overrun_d = 1'b1;
      end
    end

    // Latch sees the post-shift state so a coincident pixel is captured and counted.
    if (lat_rise) begin
      row_valid_d = 1'b1;
      row_addr_d  = row_s1_q;
      row_data_d  = buf_d;
      err_d       = (col_cnt_d != COL_W'(COLUMNS)) | overrun_d;
      col_cnt_d   = '0;
      overrun_d   = 1'b0;
    end
  end

  always_comb begin
    ot_sum      = (&ot_cnt_q) ? ot_cnt_q : ot_cnt_q + ONTIME_WIDTH'(oe_s1_q);
    ot_cnt_d    = ot_sum;
    ot_valid_d  = 1'b0;
    ot_row_d    = ot_row_q;
    ot_cycles_d = ot_cycles_q;
    if (row_s1_q != row_s2_q) begin
      ot_valid_d  = 1'b1;
      ot_row_d    = row_s2_q;
      ot_cycles_d = ot_sum;
      ot_cnt_d    = ONTIME_WIDTH'(oe_s1_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_s1_q    <= '0;
      oe_s1_q     <= 1'b0;
      row_s1_q    <= '0;
      row_s2_q    <= '0;
      col_cnt_q   <= '0;
      overrun_q   <= 1'b0;
      buf_q       <= '0;
      row_valid_q <= 1'b0;
      err_q       <= 1'b0;
      row_addr_q  <= '0;
      row_data_q  <= '0;
      ot_cnt_q    <= '0;
      ot_valid_q  <= 1'b0;
      ot_row_q    <= '0;
      ot_cycles_q <= '0;
    end else begin
      rgb_s1_q    <= rgb_s1_d;
      oe_s1_q     <= oe_s1_d;
      row_s1_q    <= row_s1_d;
      row_s2_q    <= row_s2_d;
      col_cnt_q   <= col_cnt_d;
      overrun_q   <= overrun_d;
      buf_q       <= buf_d;
      row_valid_q <= row_valid_d;
      err_q       <= err_d;
      row_addr_q  <= row_addr_d;
      row_data_q  <= row_data_d;
      ot_cnt_q    <= ot_cnt_d;
      ot_valid_q  <= ot_valid_d;
      ot_row_q    <= ot_row_d;
      ot_cycles_q <= ot_cycles_d;
    end
  end

  assign row_valid     = row_valid_q;
  assign row_addr      = row_addr_q;
  assign row_data      = row_data_q;
  assign err_count     = err_q;
  assign ontime_valid  = ot_valid_q;
  assign ontime_row    = ot_row_q;
  assign ontime_cycles = ot_cycles_q;

`ifdef HUB75_RX_FRAME_STATS_EN
  logic [31:0] frame_cnt_q, frame_cnt_d, frame_cycles_q, frame_cycles_d;
  logic        frame_valid_q, frame_valid_d;

  // A frame closes when the scan wraps from the last row back to row 0.
  always_comb begin
    frame_cnt_d    = frame_cnt_q + 32'd1;
    frame_valid_d  = 1'b0;
    frame_cycles_d = frame_cycles_q;
    if (row_s1_q != row_s2_q && row_s2_q == ROW_W'(ROWS - 1) && row_s1_q == '0) begin
      frame_valid_d  = 1'b1;
      frame_cycles_d = frame_cnt_q + 32'd1;
      frame_cnt_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q    <= '0;
      frame_valid_q  <= 1'b0;
      frame_cycles_q <= '0;
    end else begin
      frame_cnt_q    <= frame_cnt_d;
      frame_valid_q  <= frame_valid_d;
      frame_cycles_q <= frame_cycles_d;
    end
  end

  assign frame_valid  = frame_valid_q;
  assign frame_cycles = frame_cycles_q;
`endif
endmodule

// File: tb/tb_hub75_panel_receiver.sv
// Randomized bench for hub75_panel_receiver against a row/pixel-level reference model.
module tb_hub75_panel_receiver;
  localparam int COLS = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [2:0] in_rgb, in_row;
  logic       in_oclk, in_lat, in_oe;

  logic        row_valid, err_count, ontime_valid;
  logic [2:0]  row_addr, ontime_row;
  logic [95:0] row_data;
  logic [23:0] ontime_cycles;
  logic        row_valid4, err_count4, ontime_valid4;
  logic [2:0]  row_addr4, ontime_row4;
  logic [95:0] row_data4;
  logic [3:0]  ontime_cycles4;
`ifdef HUB75_RX_FRAME_STATS_EN
  logic        frame_valid, frame_valid4;
  logic [31:0] frame_cycles, frame_cycles4;
`endif

  hub75_panel_receiver u_dut (
    .clk(clk), .rst(rst), .in_rgb(in_rgb), .in_oclk(in_oclk), .in_lat(in_lat),
    .in_oe(in_oe), .in_row(in_row), .row_valid(row_valid), .row_addr(row_addr),
    .row_data(row_data), .err_count(err_count), .ontime_valid(ontime_valid),
    .ontime_row(ontime_row), .ontime_cycles(ontime_cycles)
`ifdef HUB75_RX_FRAME_STATS_EN
    , .frame_valid(frame_valid), .frame_cycles(frame_cycles)
`endif
  );

  hub75_panel_receiver #(.ONTIME_WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_rgb(in_rgb), .in_oclk(in_oclk), .in_lat(in_lat),
    .in_oe(in_oe), .in_row(in_row), .row_valid(row_valid4), .row_addr(row_addr4),
    .row_data(row_data4), .err_count(err_count4), .ontime_valid(ontime_valid4),
    .ontime_row(ontime_row4), .ontime_cycles(ontime_cycles4)
`ifdef HUB75_RX_FRAME_STATS_EN
    , .frame_valid(frame_valid4), .frame_cycles(frame_cycles4)
`endif
  );

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  typedef struct { logic [2:0] addr; logic [95:0] data; logic err; } row_rep_t;
  typedef struct { logic [2:0] row; int cyc; } ot_rep_t;

  row_rep_t   row_q[$];
  ot_rep_t    ot_q[$], ot4_q[$];
  int         pix_q[$];
  int         frame_q[$];
  logic [2:0] mbuf[COLS];
  logic [2:0] m_row, cur_row;
  logic       cur_oe, prev_oclk, prev_lat;
  int         m_cnt, samp, prev_fidx;

  task automatic model_reset();
    pix_q.delete(); row_q.delete(); ot_q.delete(); ot4_q.delete(); frame_q.delete();
    for (int c = 0; c < COLS; c++) mbuf[c] = 3'd0;
    m_row = 3'd0; m_cnt = 0; samp = 0; prev_fidx = -1;
    prev_oclk = 1'b0; prev_lat = 1'b0;
  endtask

  // One clock of stimulus; the model sees exactly what the DUT samples on the next edge.
  task automatic step(input logic [2:0] rgb, input logic oclk, input logic lat);
    logic     oe;
    int       n;
    row_rep_t r;
    ot_rep_t  o;
    @(negedge clk);
    oe = (cur_row != m_row) ? 1'b0 : cur_oe;
    in_rgb = rgb; in_oclk = oclk; in_lat = lat; in_row = cur_row; in_oe = oe;
    samp++;
    if (oclk && !prev_oclk) pix_q.push_back(int'(rgb));
    if (lat && !prev_lat) begin
      n = pix_q.size();
      for (int c = 0; c < COLS && c < n; c++) mbuf[c] = 3'(pix_q[c]);
      r.data = '0;
      for (int c = 0; c < COLS; c++) r.data[c*3 +: 3] = mbuf[c];
      r.addr = cur_row;
      r.err  = (n != COLS);
      row_q.push_back(r);
      pix_q.delete();
    end
    if (cur_row != m_row) begin
      o.row = m_row; o.cyc = m_cnt;
      ot_q.push_back(o); ot4_q.push_back(o);
      if (m_row == 3'd7 && cur_row == 3'd0) frame_q.push_back(samp);
      m_row = cur_row; m_cnt = 0;
    end else begin
      m_cnt += int'(oe);
    end
    prev_oclk = oclk; prev_lat = lat;
  endtask

  task automatic idle(input int n);
    repeat (n) step(3'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_oclk = 1'b0; in_lat = 1'b0; in_oe = 1'b0; in_rgb = 3'd0; in_row = 3'd0;
    repeat (3) @(negedge clk);
    model_reset();
    rst = 1'b0;
  endtask

  task automatic shift_px(input logic [2:0] v);
    step(v, 1'b1, 1'b0);
    step(v, 1'b0, 1'b0);
  endtask

  task automatic latch();
    step(3'd0, 1'b0, 1'b1);
    step(3'd0, 1'b0, 1'b0);
  endtask

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  row_rep_t    me;
  ot_rep_t     oe_m, oe_m4;
  int          n_rv = 0, fidx;
  logic [95:0] last_data;
  logic [2:0]  last_addr, last_ot_row;
  logic        last_err;
  int          last_ot, last_ot4;
  logic [31:0] last_fc = 32'd0;

  always @(negedge clk) begin
    if (!rst) begin
      if (row_valid) begin
        n_rv++;
        last_data = row_data; last_err = err_count; last_addr = row_addr;
        if (row_q.size() == 0) chk("row_extra", 1, 0);
        else begin
          me = row_q.pop_front();
          chk("row_addr", row_addr, me.addr);
          chk("row_data", row_data, me.data);
          chk("err_count", err_count, me.err);
        end
      end
      if (ontime_valid) begin
        last_ot = int'(ontime_cycles); last_ot_row = ontime_row;
        if (ot_q.size() == 0) chk("ot_extra", 1, 0);
        else begin
          oe_m = ot_q.pop_front();
          chk("ot_row", ontime_row, oe_m.row);
          chk("ot_cycles", ontime_cycles, sat(oe_m.cyc, 24));
        end
      end
      if (ontime_valid4) begin
        last_ot4 = int'(ontime_cycles4);
        if (ot4_q.size() == 0) chk("ot4_extra", 1, 0);
        else begin
          oe_m4 = ot4_q.pop_front();
          chk("ot4_row", ontime_row4, oe_m4.row);
          chk("ot4_cycles", ontime_cycles4, sat(oe_m4.cyc, 4));
        end
      end
`ifdef HUB75_RX_FRAME_STATS_EN
      if (frame_valid) begin
        last_fc = frame_cycles;
        if (frame_q.size() == 0) chk("frame_extra", 1, 0);
        else begin
          fidx = frame_q.pop_front();
          if (prev_fidx >= 0) chk("frame_cycles", frame_cycles, fidx - prev_fidx);
          prev_fidx = fidx;
        end
      end
`endif
    end
  end

  logic [95:0] pat;
  int          rv0, n, hold;
  logic [2:0]  v;
  bit          coinc;

  initial begin
    cur_row = 3'd0; cur_oe = 1'b0;
    model_reset();
    do_reset();
    @(negedge clk);
    chk("rst_row_valid", row_valid, 0);
    chk("rst_row_data", row_data, 0);
    chk("rst_err", err_count, 0);
    chk("rst_ot_valid", ontime_valid, 0);
    chk("rst_ot_cycles", ontime_cycles, 0);

    // Full row with a counting pattern, latched into row 3.
    cur_row = 3'd3;
    idle(2);
    rv0 = n_rv;
    for (int c = 0; c < COLS; c++) shift_px(3'(c));
    latch();
    idle(4);
    pat = '0;
    for (int c = 0; c < COLS; c++) pat[c*3 +: 3] = 3'(c % 8);
    chk("full_rv_count", n_rv - rv0, 1);
    chk("full_addr", last_addr, 3);
    chk("full_data", last_data, pat);
    chk("full_err", last_err, 0);

    for (int c = 0; c < 31; c++) shift_px(3'(c + 2));
    latch(); idle(4);
    chk("short_err", last_err, 1);
    for (int c = 0; c < 33; c++) shift_px(3'(7 - c));
    latch(); idle(4);
    chk("long_err", last_err, 1);

    // 32nd pixel and latch rise in the same cycle.
    for (int c = 0; c < 31; c++) shift_px(3'(c));
    step(3'd5, 1'b1, 1'b1);
    step(3'd0, 1'b0, 1'b0);
    idle(4);
    chk("coinc_err", last_err, 0);
    chk("coinc_col31", last_data[93 +: 3], 5);

    // Latch held high must produce a single row.
    rv0 = n_rv;
    repeat (6) step(3'd0, 1'b0, 1'b1);
    idle(4);
    chk("lat_hold_count", n_rv - rv0, 1);

    // On-time: 100 lit + 20 dark on row 2.
    cur_row = 3'd2; cur_oe = 1'b0; idle(1);
    cur_oe = 1'b1; idle(100);
    cur_oe = 1'b0; idle(20);
    cur_row = 3'd3; idle(4);
    chk("ot100_row", last_ot_row, 2);
    chk("ot100_cycles", last_ot, 100);
    chk("ot100_sat4", last_ot4, 15);
    cur_oe = 1'b1; idle(40);
    cur_oe = 1'b0; cur_row = 3'd4; idle(4);
    chk("ot40_cycles", last_ot, 40);
    chk("ot40_sat4", last_ot4, 15);

    // Reset in the middle of a row.
    for (int c = 0; c < 10; c++) shift_px(3'(c));
    do_reset();
    @(negedge clk);
    chk("post_rst_rv", row_valid, 0);
    chk("post_rst_ot", ontime_valid, 0);
    latch(); idle(4);
    chk("rst_mid_err", last_err, 1);
    chk("rst_mid_data", last_data, 0);

    for (int it = 0; it < 12; it++) begin
      n = $urandom_range(28, 36);
      coinc = 1'($urandom_range(0, 1));
      cur_row = 3'($urandom_range(0, 7));
      for (int c = 0; c < n; c++) begin
        v = 3'($urandom);
        cur_oe = 1'($urandom_range(0, 1));
        if (coinc && c == n - 1) begin
          step(v, 1'b1, 1'b1);
          step(3'd0, 1'b0, 1'b0);
        end else begin
          step(v, 1'b1, 1'b0);
          repeat ($urandom_range(1, 2)) step(v, 1'b0, 1'b0);
        end
      end
      if (!coinc) begin
        hold = $urandom_range(1, 3);
        repeat (hold) step(3'd0, 1'b0, 1'b1);
        step(3'd0, 1'b0, 1'b0);
      end
      idle($urandom_range(1, 6));
    end

`ifdef HUB75_RX_FRAME_STATS_EN
    for (int f = 0; f < 3; f++)
      for (int r = 0; r < 8; r++) begin
        cur_row = 3'(r);
        cur_oe = 1'($urandom_range(0, 1));
        idle(1000);
      end
    cur_row = 3'd0; idle(5);
    chk("frame_8000", last_fc, 8000);
`endif

    idle(10);
    chk("rows_pending", row_q.size(), 0);
    chk("ot_pending", ot_q.size(), 0);
    chk("ot4_pending", ot4_q.size(), 0);
    chk("frame_pending", frame_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
